// File: rtl/bin2gray_counter.sv
// bin2gray_counter: free-running binary counter with a registered Gray-code copy.
// Built to generate the pointer on the encoding side of an async FIFO.
// gray_o comes straight from a flop and so is safe to synchronise into another
// clock domain. A synchronous load takes priority over an increment.
// gray_next_o gives the Gray code of the next count for full/empty lookahead.
module bin2gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   output logic [WIDTH-1:0] bin_o,
   output logic [WIDTH-1:0] gray_o,
   output logic [WIDTH-1:0] gray_next_o,
   output logic             wrap_o
);

   // Binary to reflected Gray code. The MSB passes through unchanged.
   function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             wrap_q;
   logic [WIDTH-1:0] bin_plus_one;
   logic [WIDTH-1:0] bin_next;
   logic             wrap_next;

   // The carry out of the MSB is dropped, so all-ones wraps to zero.
   assign bin_plus_one = bin_q + ONE;

   // Choose the next count. Load wins over increment, and a load never flags a wrap.
   always_comb begin
      bin_next  = bin_q;
      wrap_next = 1'b0;
      if (load_i) begin
         bin_next  = load_data_i;
         wrap_next = 1'b0;
      end else if (inc_i) begin
         bin_next  = bin_plus_one;
         wrap_next = &bin_q;
      end else begin
         bin_next  = bin_q;
         wrap_next = 1'b0;
      end
   end

   // State update. The Gray code is encoded before the flop, so gray_o has no output logic.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bin_q  <= {WIDTH{1'b0}};
         gray_q <= {WIDTH{1'b0}};
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_next;
         gray_q <= bin_to_gray(bin_next);
         wrap_q <= wrap_next;
      end
   end

   assign bin_o       = bin_q;
   assign gray_o      = gray_q;
   assign wrap_o      = wrap_q;
   assign gray_next_o = bin_to_gray(bin_plus_one);

endmodule

// File: tb/tb_bin2gray_counter.sv
// Scoreboard testbench for bin2gray_counter with WIDTH = 4.
// Each driven edge pushes its expected outputs, and they are popped after the edge.
module tb_bin2gray_counter;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] bin;
      logic [W-1:0] gray;
      logic [W-1:0] gnext;
      logic         wrap;
   } exp_t;

   logic         clk_i;
   logic         rst_ni;
   logic         inc_i;
   logic         load_i;
   logic [W-1:0] load_data_i;
   logic [W-1:0] bin_o;
   logic [W-1:0] gray_o;
   logic [W-1:0] gray_next_o;
   logic         wrap_o;

   int           n_cmp;
   int           n_err;
   exp_t         sb_q[$];
   logic [W-1:0] model_bin;
   logic [W-1:0] gray_tab [16];

   bin2gray_counter #(.WIDTH(W)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (inc_i),
      .load_i      (load_i),
      .load_data_i (load_data_i),
      .bin_o       (bin_o),
      .gray_o      (gray_o),
      .gray_next_o (gray_next_o),
      .wrap_o      (wrap_o)
   );

   // 10 ns clock.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, push the expected result, then compare after the edge.
   task automatic step(input logic inc, input logic load, input logic [W-1:0] data, input string tag);
      exp_t         e;
      exp_t         got;
      logic [W-1:0] prev_gray;
      @(negedge clk_i);
      inc_i       = inc;
      load_i      = load;
      load_data_i = data;
      prev_gray   = gray_o;
      e.wrap      = 1'b0;
      if (load) begin
         model_bin = data;
      end else if (inc) begin
         e.wrap    = (model_bin == 4'd15);
         model_bin = model_bin + 4'd1;
      end
      e.bin   = model_bin;
      e.gray  = gray_tab[model_bin];
      e.gnext = gray_tab[4'(model_bin + 4'd1)];
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      if (sb_q.size() == 0) begin
         check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb_q.pop_front();
         check_value({tag, "_bin"},   {28'd0, bin_o},       {28'd0, got.bin});
         check_value({tag, "_gray"},  {28'd0, gray_o},      {28'd0, got.gray});
         check_value({tag, "_gnext"}, {28'd0, gray_next_o}, {28'd0, got.gnext});
         check_value({tag, "_wrap"},  {31'd0, wrap_o},      {31'd0, got.wrap});
         if (inc && !load) begin
            check_value({tag, "_onebit"}, $countones(gray_o ^ prev_gray), 32'd1);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_bin"},   {28'd0, bin_o},       32'd0);
      check_value({tag, "_gray"},  {28'd0, gray_o},      32'd0);
      check_value({tag, "_wrap"},  {31'd0, wrap_o},      32'd0);
      check_value({tag, "_gnext"}, {28'd0, gray_next_o}, 32'd1);
   endtask

   initial begin
      gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                   4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
      n_cmp       = 0;
      n_err       = 0;
      model_bin   = 4'd0;
      rst_ni      = 1'b0;
      inc_i       = 1'b0;
      load_i      = 1'b0;
      load_data_i = 4'd0;

      // Reset held for three cycles, then released with no requests.
      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(1'b0, 1'b0, 4'd0, "idle0");
      step(1'b0, 1'b0, 4'd0, "idle1");

      // Full sweep of 16 increments. The last one wraps from 15 to 0.
      check_value("sweep_start", {28'd0, gray_o}, {28'd0, gray_tab[0]});
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0, 4'd0, "sweep");
      end
      // The wrap pulse lasts exactly one cycle while counting continues.
      step(1'b1, 1'b0, 4'd0, "post_wrap");

      // Load takes priority over increment.
      step(1'b1, 1'b1, 4'd5, "load5");
      check_value("load5_gray_lit", {28'd0, gray_o}, 32'h7);
      check_value("load5_gnext_lit", {28'd0, gray_next_o}, 32'h5);
      // Loading 0 while at all-ones must not raise wrap.
      step(1'b0, 1'b1, 4'd15, "load15");
      step(1'b1, 1'b1, 4'd0, "load0_from15");

      // Stall pattern starting from 6.
      step(1'b0, 1'b1, 4'd6, "load6");
      step(1'b1, 1'b0, 4'd0, "stall_a");
      step(1'b0, 1'b0, 4'd0, "stall_b");
      step(1'b0, 1'b0, 4'd0, "stall_c");
      step(1'b1, 1'b0, 4'd0, "stall_d");
      check_value("stall_gray_lit", {28'd0, gray_o}, 32'hC);

      // Asynchronous reset between edges while the count is 9.
      step(1'b0, 1'b1, 4'd9, "load9");
      @(negedge clk_i);
      inc_i  = 1'b0;
      load_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_bin = 4'd0;
      sb_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(1'b1, 1'b0, 4'd0, "after_rst1");
      step(1'b1, 1'b0, 4'd0, "after_rst2");
      check_value("after_rst_gray_lit", {28'd0, gray_o}, 32'h3);

      // Asynchronous reset clears a wrap pulse that is still high.
      step(1'b0, 1'b1, 4'd15, "load15b");
      step(1'b1, 1'b0, 4'd0, "wrap_b");
      @(negedge clk_i);
      inc_i  = 1'b0;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("rst_wrap");
      @(negedge clk_i);
      rst_ni = 1'b1;
      model_bin = 4'd0;
      step(1'b0, 1'b0, 4'd0, "final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
